// File: rtl/firebird7_in_gate1_tdr_pkg.sv
// Shared constants, scan-segment field map and operation decode for the
// firebird7_in gate1 IJTAG override TDR.
package firebird7_in_gate1_tdr_pkg;

  localparam int TDR_WIDTH = 19;
  localparam int TDR_LEN   = TDR_WIDTH + 2;

  // Field positions inside the scan segment.
  localparam int SEL_BIT  = 0;
  localparam int DATA_LSB = 1;
  localparam int STAT_BIT = TDR_WIDTH + 1;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_CAPTURE,
    OP_SHIFT,
    OP_UPDATE
  } tdr_op_e;

  // Shift counter width: wide enough to hold a full segment plus one.
  function automatic int CNT_W(input int width);
    return $clog2(width + 3);
  endfunction

  // Only one operation acts per edge: capture beats shift beats update.
  function automatic tdr_op_e decode_op(input logic sel, input logic ce,
                                        input logic se, input logic ue);
    tdr_op_e op;
    op = OP_NONE;
    if (sel) begin
      if (ce)      op = OP_CAPTURE;
      else if (se) op = OP_SHIFT;
      else if (ue) op = OP_UPDATE;
    end
    return op;
  endfunction

endpackage

// File: rtl/firebird7_in_gate1_tdr_len_chk.sv
// Shift-length checker: tracks whether a capture was seen and how many bits
// have been shifted since, and decides whether an update may be accepted.
module firebird7_in_gate1_tdr_len_chk
  import firebird7_in_gate1_tdr_pkg::*;
#(
  parameter int WIDTH        = TDR_WIDTH,
  parameter bit LENGTH_CHECK = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_capture,
  input  logic i_shift,
  input  logic i_update,
  output logic o_update_ok
);

  localparam int              CW       = CNT_W(WIDTH);
  localparam logic [CW-1:0]   CNT_MAX  = '1;
  localparam logic [CW-1:0]   CNT_FULL = CW'(WIDTH + 2);

  logic [CW-1:0] r_cnt;
  logic          r_armed;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, matching real hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_armed <= 1'b0;
    end else if (i_capture) begin
      r_cnt   <= '0;
      r_armed <= 1'b1;
    end else if (i_shift) begin
      if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
    end else if (i_update) begin
      r_cnt   <= '0;
      r_armed <= 1'b0;
    end
  end

  // Saturation keeps an over-long shift from wrapping back to an exact count.
  assign o_update_ok = (LENGTH_CHECK == 1'b0) || (r_armed && (r_cnt == CNT_FULL));

endmodule

// File: rtl/firebird7_in_gate1_tessent_tdr_w19_ctl.sv
// IJTAG TDR feeding the gate1 19-bit IJTAG/functional mux: observes functional
// data on capture, shifts a WIDTH+2 segment, and loads data/select on update.
module firebird7_in_gate1_tessent_tdr_w19_ctl
  import firebird7_in_gate1_tdr_pkg::*;
#(
  parameter int WIDTH        = TDR_WIDTH,
  parameter bit LENGTH_CHECK = 1'b1
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             ijtag_sel,
  input  logic             ijtag_ce,
  input  logic             ijtag_se,
  input  logic             ijtag_ue,
  input  logic             ijtag_si,
  output logic             ijtag_so,
  input  logic [WIDTH-1:0] functional_data_in,
  output logic [WIDTH-1:0] ijtag_data_out,
  output logic             ijtag_select_out,
  output logic             update_rejected
);

  localparam int LEN = WIDTH + 2;

  tdr_op_e          w_op;
  logic             w_update_ok;
  logic [LEN-1:0]   r_sr;
  logic [WIDTH-1:0] r_data_q;
  logic             r_select_q;
  logic             r_update_rejected;

  assign w_op = decode_op(ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue);

  firebird7_in_gate1_tdr_len_chk #(
    .WIDTH        (WIDTH),
    .LENGTH_CHECK (LENGTH_CHECK)
  ) u_len_chk (
    .clk         (ijtag_tck),
    .rst_n       (ijtag_reset),
    .i_capture   (w_op == OP_CAPTURE),
    .i_shift     (w_op == OP_SHIFT),
    .i_update    (w_op == OP_UPDATE),
    .o_update_ok (w_update_ok)
  );

  // Capture packs {status, functional data, current select}.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      r_sr <= '0;
    end else begin
      case (w_op)
        OP_CAPTURE: r_sr <= {r_update_rejected, functional_data_in, r_select_q};
        OP_SHIFT:   r_sr <= {ijtag_si, r_sr[LEN-1:1]};
        default:    r_sr <= r_sr;
      endcase
    end
  end

  // Select must come out of reset low so the downstream mux passes functional data.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      r_data_q          <= '0;
      r_select_q        <= 1'b0;
      r_update_rejected <= 1'b0;
    end else if (w_op == OP_UPDATE) begin
      if (w_update_ok) begin
        r_data_q          <= r_sr[WIDTH:DATA_LSB];
        r_select_q        <= r_sr[SEL_BIT];
        r_update_rejected <= 1'b0;
      end else begin
        r_update_rejected <= 1'b1;
      end
    end
  end

  assign ijtag_so         = r_sr[SEL_BIT];
  assign ijtag_data_out   = r_data_q;
  assign ijtag_select_out = r_select_q;
  assign update_rejected  = r_update_rejected;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_w19_ctl.sv
// Scoreboard bench for the gate1 override TDR: stimulus queues expected
// values, a negedge monitor pops and compares them.
module tb_firebird7_in_gate1_tessent_tdr_w19_ctl;

  logic        ijtag_tck = 1'b0;
  logic        ijtag_reset;
  logic        ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si;
  logic        ijtag_so;
  logic [18:0] functional_data_in;
  logic [18:0] ijtag_data_out;
  logic        ijtag_select_out;
  logic        update_rejected;

  always #5 ijtag_tck = ~ijtag_tck;

  firebird7_in_gate1_tessent_tdr_w19_ctl #(
    .WIDTH        (19),
    .LENGTH_CHECK (1'b1)
  ) dut (
    .ijtag_tck          (ijtag_tck),
    .ijtag_reset        (ijtag_reset),
    .ijtag_sel          (ijtag_sel),
    .ijtag_ce           (ijtag_ce),
    .ijtag_se           (ijtag_se),
    .ijtag_ue           (ijtag_ue),
    .ijtag_si           (ijtag_si),
    .ijtag_so           (ijtag_so),
    .functional_data_in (functional_data_in),
    .ijtag_data_out     (ijtag_data_out),
    .ijtag_select_out   (ijtag_select_out),
    .update_rejected    (update_rejected)
  );

  // kind 0: compare data/select/rejected; kind 1: compare scan-out bit.
  typedef struct packed {
    logic        kind;
    logic [18:0] data;
    logic        sel;
    logic        rej;
    logic        so;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  function automatic void push_outs(input string nm, input logic [18:0] d,
                                    input logic s, input logic r);
    exp_t e;
    e = '{kind: 1'b0, data: d, sel: s, rej: r, so: 1'b0};
    exp_q.push_back(e);
    name_q.push_back(nm);
  endfunction

  function automatic void push_so(input string nm, input logic b);
    exp_t e;
    e = '{kind: 1'b1, data: '0, sel: 1'b0, rej: 1'b0, so: b};
    exp_q.push_back(e);
    name_q.push_back(nm);
  endfunction

  initial begin
    forever begin
      @(negedge ijtag_tck);
      while (exp_q.size() > 0) begin
        exp_t  e;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_tests++;
        if (e.kind) begin
          if (ijtag_so !== e.so) begin
            n_fail++;
            $display("FAIL %s: so=%b expected %b", nm, ijtag_so, e.so);
          end
        end else if ({ijtag_data_out, ijtag_select_out, update_rejected} !==
                     {e.data, e.sel, e.rej}) begin
          n_fail++;
          $display("FAIL %s: data=%h sel=%b rej=%b expected data=%h sel=%b rej=%b",
                   nm, ijtag_data_out, ijtag_select_out, update_rejected,
                   e.data, e.sel, e.rej);
        end
      end
    end
  end

  // One TCK cycle: drive controls, let the edge happen, settle 1 ns past it.
  task automatic cyc(input logic ce, input logic se, input logic ue, input logic si);
    ijtag_ce = ce;
    ijtag_se = se;
    ijtag_ue = ue;
    ijtag_si = si;
    @(posedge ijtag_tck);
    #1;
    ijtag_ce = 1'b0;
    ijtag_se = 1'b0;
    ijtag_ue = 1'b0;
  endtask

  task automatic shift_in(input logic [20:0] v, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, v[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [20:0] v;
    logic [20:0] obs;

    ijtag_reset        = 1'b0;
    ijtag_sel          = 1'b0;
    ijtag_ce           = 1'b0;
    ijtag_se           = 1'b0;
    ijtag_ue           = 1'b0;
    ijtag_si           = 1'b0;
    functional_data_in = '0;

    // Reset then idle
    @(posedge ijtag_tck);
    @(posedge ijtag_tck);
    #1;
    push_outs("reset_outs", 19'h0, 1'b0, 1'b0);
    push_so("reset_so", 1'b0);
    ijtag_reset = 1'b1;
    ijtag_sel   = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    push_outs("idle_outs", 19'h0, 1'b0, 1'b0);

    // Good update: exact 21-bit shift
    v = {1'b0, 19'h5A5A5, 1'b1};
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    shift_in(v, 21);
    push_outs("pre_update_hold", 19'h0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    push_outs("good_update", 19'h5A5A5, 1'b1, 1'b0);

    // Wrong length: 20 shifts, update refused
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    shift_in(21'h1FFFFF, 20);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    push_outs("short_shift_reject", 19'h5A5A5, 1'b1, 1'b1);

    // Status bit surfaces as the 21st bit out; exact reload then clears it
    v = {1'b0, 19'h0F0F0, 1'b0};
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    push_so("status_cap_sel_bit", 1'b1);
    shift_in(v, 19);
    push_so("status_data_msb", 1'b0);
    cyc(1'b0, 1'b1, 1'b0, v[19]);
    push_so("status_bit_out", 1'b1);
    cyc(1'b0, 1'b1, 1'b0, v[20]);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    push_outs("reload_clears_reject", 19'h0F0F0, 1'b0, 1'b0);

    // Observe path: select, functional data LSB-first, status
    functional_data_in = 19'h12345;
    obs = {1'b0, 19'h12345, 1'b0};
    v   = {1'b0, 19'h3C3C3, 1'b1};
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    push_so("obs_bit0", obs[0]);
    for (int k = 1; k <= 20; k++) begin
      cyc(1'b0, 1'b1, 1'b0, v[k-1]);
      push_so($sformatf("obs_bit%0d", k), obs[k]);
    end
    cyc(1'b0, 1'b1, 1'b0, v[20]);

    // ce with ue: capture wins, the armed full-length update is ignored
    functional_data_in = 19'h7FFFF;
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    push_outs("ce_ue_hold", 19'h0F0F0, 1'b0, 1'b0);
    push_so("ce_ue_captured", 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    push_outs("update_after_capture_only", 19'h0F0F0, 1'b0, 1'b1);

    // Deselected segment holds everything, including the armed count
    functional_data_in = 19'h0;
    v = {1'b0, 19'h11111, 1'b1};
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    shift_in(v, 21);
    ijtag_sel = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    push_outs("desel_outs_hold", 19'h0F0F0, 1'b0, 1'b1);
    push_so("desel_so_hold", 1'b1);
    ijtag_sel = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    push_outs("update_after_desel", 19'h11111, 1'b1, 1'b0);

    // Reset mid-shift clears state at once, then update without capture fails
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    shift_in(21'h1FFFFF, 10);
    ijtag_reset = 1'b0;
    #1;
    push_outs("async_reset_outs", 19'h0, 1'b0, 1'b0);
    push_so("async_reset_so", 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    ijtag_reset = 1'b1;
    v = {1'b0, 19'h7FFFF, 1'b1};
    shift_in(v, 21);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    push_outs("update_without_capture", 19'h0, 1'b0, 1'b1);

    repeat (2) @(negedge ijtag_tck);
    #1;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
